// File: rtl/dac_stream_control.sv
// ---------------------------------------------------------------------------
// dac_stream_control
//
// Analog output stage of the PLL datapath. Captures each 8-bit ADC sample on
// the rising edge of the ADC controller's sample-ready level and shifts one
// 16-bit frame to a PmodDA2-class 12-bit DAC over a SYNC/SCLK/DIN link.
//
// Frame word: {2'b00 don't-care, 2'b00 normal-mode PD, sample[7:0], 4'b0000}
// Frame timing: SETUP CLK_DIV cycles, SHIFT 32*CLK_DIV cycles (16 SCLK
// periods), QUIET 2*CLK_DIV cycles -> 35*CLK_DIV cycles per frame.
//
// Optional feature: define DAC_PENDING_EN to compile in a one-entry pending
// sample register (newest wins). Without it, every strobe that arrives while
// a frame is in flight is dropped.
//
// Parameters:
//   CLK_DIV        SCLK half-period in CLK cycles (1..255)
// Ports:
//   CLK            system clock, posedge
//   RST_N          asynchronous active-low reset
//   sample_strobe  sample-ready level from the ADC; rising edge used
//   sample_in      8-bit ADC sample, stable while sample_strobe is high
//   DAC_SYNC       frame select, active low
//   DAC_SCLK       serial clock, idles high; DAC samples DIN on falling edge
//   DAC_DIN        serial data, MSB first
//   busy           high whenever the FSM is not IDLE
//   overrun_cnt    saturating count of lost samples
//   TEST_STATE     current FSM state encoding, for debug
// ---------------------------------------------------------------------------
module dac_stream_control #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       sample_strobe,
    input  logic [7:0] sample_in,
    output logic       DAC_SYNC,
    output logic       DAC_SCLK,
    output logic       DAC_DIN,
    output logic       busy,
    output logic [7:0] overrun_cnt,
    output logic [7:0] TEST_STATE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        QUIET = 2'd3
    } state_t;

    // Wide enough for the QUIET interval of 2*255-1 cycles.
    localparam logic [8:0] HALF_M1  = 9'(CLK_DIV - 1);
    localparam logic [8:0] QUIET_M1 = 9'(2 * CLK_DIV - 1);

    state_t      state;
    logic [15:0] shreg;
    logic [8:0]  cnt;
    logic [3:0]  bit_cnt;
    logic        strobe_q;
    logic        strobe_ev;
    logic        quiet_exit;
    logic        lost;
    logic        chain_ok;
    logic [7:0]  chain_data;

    assign strobe_ev  = sample_strobe & ~strobe_q;
    assign quiet_exit = (state == QUIET) && (cnt == 9'd0);
    assign TEST_STATE = {6'b000000, state};

    // NOTE: every register below uses non-blocking assignments so that all
    // state updates within a clock edge see the pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= sample_strobe;
        end
    end

`ifdef DAC_PENDING_EN
    logic       pend_valid;
    logic [7:0] pend_data;
    logic       consume;

    // A pending sample consumed on this edge frees the slot, so a strobe on
    // the same edge refills it without counting as lost.
    assign consume    = quiet_exit && pend_valid;
    assign lost       = strobe_ev && (state != IDLE) && pend_valid && !consume;
    assign chain_ok   = pend_valid;
    assign chain_data = pend_data;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_valid <= 1'b0;
            pend_data  <= 8'h00;
        end else if (strobe_ev && (state != IDLE)) begin
            pend_valid <= 1'b1;
            pend_data  <= sample_in;
        end else if (consume) begin
            pend_valid <= 1'b0;
        end
    end
`else
    assign lost       = strobe_ev && (state != IDLE);
    assign chain_ok   = 1'b0;
    assign chain_data = 8'h00;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun_cnt <= 8'h00;
        end else if (lost && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'h01;
        end
    end

    // Frame sequencer. Outputs are registered alongside the state so SYNC,
    // SCLK and DIN change together on the same edge with no decode glitches.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            DAC_SYNC <= 1'b1;
            DAC_SCLK <= 1'b1;
            DAC_DIN  <= 1'b0;
            busy     <= 1'b0;
            shreg    <= 16'h0000;
            cnt      <= 9'd0;
            bit_cnt  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe_ev) begin
                        state    <= SETUP;
                        shreg    <= {4'b0000, sample_in, 4'b0000};
                        DAC_SYNC <= 1'b0;
                        DAC_SCLK <= 1'b1;
                        DAC_DIN  <= 1'b0;  // bit 15 is always 0
                        busy     <= 1'b1;
                        cnt      <= HALF_M1;
                    end
                end

                SETUP: begin
                    if (cnt == 9'd0) begin
                        state    <= SHIFT;
                        DAC_SCLK <= 1'b0;  // falling edge samples bit 15
                        bit_cnt  <= 4'd15;
                        cnt      <= HALF_M1;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end

                SHIFT: begin
                    if (cnt != 9'd0) begin
                        cnt <= cnt - 9'd1;
                    end else if (!DAC_SCLK) begin
                        // Low phase done: raise SCLK and present the next bit,
                        // giving CLK_DIV cycles of setup before the next fall.
                        DAC_SCLK <= 1'b1;
                        shreg    <= {shreg[14:0], 1'b0};
                        DAC_DIN  <= shreg[14];
                        cnt      <= HALF_M1;
                    end else if (bit_cnt == 4'd0) begin
                        state    <= QUIET;
                        DAC_SYNC <= 1'b1;
                        DAC_DIN  <= 1'b0;
                        cnt      <= QUIET_M1;
                    end else begin
                        DAC_SCLK <= 1'b0;
                        bit_cnt  <= bit_cnt - 4'd1;
                        cnt      <= HALF_M1;
                    end
                end

                QUIET: begin
                    if (cnt != 9'd0) begin
                        cnt <= cnt - 9'd1;
                    end else if (chain_ok) begin
                        state    <= SETUP;
                        shreg    <= {4'b0000, chain_data, 4'b0000};
                        DAC_SYNC <= 1'b0;
                        DAC_SCLK <= 1'b1;
                        DAC_DIN  <= 1'b0;
                        cnt      <= HALF_M1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_stream_control.sv
// ---------------------------------------------------------------------------
// tb_dac_stream_control
//
// Directed self-checking bench for dac_stream_control with CLK_DIV=2.
// A bus monitor reassembles DIN bits on each SCLK falling edge and closes a
// frame when SYNC rises; frames with other than 16 falling edges are tallied
// as partial. Expectations follow the DAC_PENDING_EN build setting.
// ---------------------------------------------------------------------------
module tb_dac_stream_control;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       sample_strobe = 1'b0;
    logic [7:0] sample_in = 8'h00;
    logic       DAC_SYNC;
    logic       DAC_SCLK;
    logic       DAC_DIN;
    logic       busy;
    logic [7:0] overrun_cnt;
    logic [7:0] TEST_STATE;

    int checks = 0;
    int errors = 0;

    dac_stream_control #(.CLK_DIV(2)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .sample_strobe(sample_strobe),
        .sample_in    (sample_in),
        .DAC_SYNC     (DAC_SYNC),
        .DAC_SCLK     (DAC_SCLK),
        .DAC_DIN      (DAC_DIN),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt),
        .TEST_STATE   (TEST_STATE)
    );

    always #5 CLK = ~CLK;

    // Bus monitor.
    logic [15:0] mon_sr = 16'h0000;
    int          mon_bits = 0;
    int          partial_cnt = 0;
    logic [15:0] frames[$];

    always @(negedge DAC_SCLK or posedge DAC_SYNC) begin
        if (DAC_SYNC === 1'b1) begin
            if (mon_bits == 16) frames.push_back(mon_sr);
            else if (mon_bits != 0) partial_cnt++;
            mon_bits = 0;
        end else begin
            mon_sr = {mon_sr[14:0], DAC_DIN};
            mon_bits++;
        end
    end

    int busy_cyc = 0;
    int sync_low_cyc = 0;

    always @(negedge CLK) begin
        if (busy === 1'b1) busy_cyc++;
        if (DAC_SYNC === 1'b0) sync_low_cyc++;
    end

    task automatic pulse(input logic [7:0] data);
        @(negedge CLK);
        sample_in     = data;
        sample_strobe = 1'b1;
        @(negedge CLK);
        sample_strobe = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge CLK);
            if (busy === 1'b0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: busy still high after %0d cycles, required low", name, budget);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic check_frames(input string name, input int n,
                                input logic [15:0] f0, input logic [15:0] f1);
        checks++;
        if (frames.size() != n) begin
            errors++;
            $display("FAIL %s frame count: got %0d required %0d", name, frames.size(), n);
        end else begin
            if (n > 0) begin
                checks++;
                if (frames[0] !== f0) begin
                    errors++;
                    $display("FAIL %s frame0: got %h required %h", name, frames[0], f0);
                end
            end
            if (n > 1) begin
                checks++;
                if (frames[1] !== f1) begin
                    errors++;
                    $display("FAIL %s frame1: got %h required %h", name, frames[1], f1);
                end
            end
        end
    endtask

    task automatic test_reset;
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({DAC_SYNC, DAC_SCLK, DAC_DIN, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL reset outputs: got sync/sclk/din/busy=%b required 1100",
                     {DAC_SYNC, DAC_SCLK, DAC_DIN, busy});
        end
        checks++;
        if (overrun_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset overrun: got %0d required 0", overrun_cnt);
        end
        checks++;
        if (TEST_STATE !== 8'h00) begin
            errors++;
            $display("FAIL reset state: got %0d required 0", TEST_STATE);
        end
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_single;
        int b0, s0;
        frames.delete();
        b0 = busy_cyc;
        s0 = sync_low_cyc;
        pulse(8'hA5);
        checks++;
        if ({DAC_SYNC, DAC_SCLK, DAC_DIN, busy} !== 4'b0101 || TEST_STATE !== 8'h01) begin
            errors++;
            $display("FAIL single setup entry: got sync/sclk/din/busy=%b state=%0d required 0101 state=1",
                     {DAC_SYNC, DAC_SCLK, DAC_DIN, busy}, TEST_STATE);
        end
        wait_idle("single", 200);
        check_frames("single", 1, 16'h0A50, 16'h0000);
        checks++;
        if (busy_cyc - b0 != 70) begin
            errors++;
            $display("FAIL single busy cycles: got %0d required 70", busy_cyc - b0);
        end
        checks++;
        if (sync_low_cyc - s0 != 66) begin
            errors++;
            $display("FAIL single sync low cycles: got %0d required 66", sync_low_cyc - s0);
        end
        checks++;
        if (overrun_cnt !== 8'h00) begin
            errors++;
            $display("FAIL single overrun: got %0d required 0", overrun_cnt);
        end
    endtask

    task automatic test_held_level;
        frames.delete();
        @(negedge CLK);
        sample_in     = 8'h3C;
        sample_strobe = 1'b1;
        repeat (200) @(negedge CLK);
        sample_strobe = 1'b0;
        wait_idle("held", 200);
        check_frames("held", 1, 16'h03C0, 16'h0000);
        checks++;
        if (overrun_cnt !== 8'h00) begin
            errors++;
            $display("FAIL held overrun: got %0d required 0", overrun_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int b0;
        frames.delete();
        b0 = busy_cyc;
        pulse(8'h11);
        repeat (8) @(negedge CLK);
        pulse(8'h22);
        repeat (18) @(negedge CLK);
        pulse(8'h33);
        wait_idle("chain", 300);
`ifdef DAC_PENDING_EN
        check_frames("chain", 2, 16'h0110, 16'h0330);
        checks++;
        if (busy_cyc - b0 != 140) begin
            errors++;
            $display("FAIL chain busy cycles: got %0d required 140", busy_cyc - b0);
        end
        checks++;
        if (overrun_cnt !== 8'd1) begin
            errors++;
            $display("FAIL chain overrun: got %0d required 1", overrun_cnt);
        end
`else
        check_frames("chain", 1, 16'h0110, 16'h0000);
        checks++;
        if (busy_cyc - b0 != 70) begin
            errors++;
            $display("FAIL chain busy cycles: got %0d required 70", busy_cyc - b0);
        end
        checks++;
        if (overrun_cnt !== 8'd2) begin
            errors++;
            $display("FAIL chain overrun: got %0d required 2", overrun_cnt);
        end
`endif
    endtask

    task automatic test_midframe_reset;
        int  p0;
        bit  reached;
        frames.delete();
        p0 = partial_cnt;
        reached = 1'b0;
        pulse(8'h5A);
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge CLK);
            if (mon_bits == 9) reached = 1'b1;  // bit 7 just sampled
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL midreset: bit 7 not reached, saw %0d bits required 9", mon_bits);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({DAC_SYNC, DAC_SCLK, DAC_DIN, busy} !== 4'b1100 || TEST_STATE !== 8'h00) begin
            errors++;
            $display("FAIL midreset outputs: got sync/sclk/din/busy=%b state=%0d required 1100 state=0",
                     {DAC_SYNC, DAC_SCLK, DAC_DIN, busy}, TEST_STATE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (partial_cnt - p0 != 1) begin
            errors++;
            $display("FAIL midreset partial frames: got %0d required 1", partial_cnt - p0);
        end
        pulse(8'hC3);
        wait_idle("after reset", 200);
        check_frames("after reset", 1, 16'h0C30, 16'h0000);
        checks++;
        if (overrun_cnt !== 8'h00) begin
            errors++;
            $display("FAIL midreset overrun: got %0d required 0", overrun_cnt);
        end
    endtask

    task automatic test_overrun_saturation;
        for (int i = 0; i < 10; i++) pulse(8'(i));
        checks++;
`ifdef DAC_PENDING_EN
        if (overrun_cnt !== 8'd8) begin
            errors++;
            $display("FAIL overrun after 10 strobes: got %0d required 8", overrun_cnt);
        end
`else
        if (overrun_cnt !== 8'd9) begin
            errors++;
            $display("FAIL overrun after 10 strobes: got %0d required 9", overrun_cnt);
        end
`endif
        for (int i = 10; i < 300; i++) pulse(8'(i));
        wait_idle("saturation", 300);
        checks++;
        if (overrun_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL overrun saturation: got %0d required 255", overrun_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held_level();
        test_back_to_back();
        test_midframe_reset();
        test_overrun_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
